// File: rtl/brp_pkg.sv
// Shared definitions for the EX-stage branch resolver: op encodings, link-register
// detection and the width of the squash counter.
package brp_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BLT  = 4'd3,
        OP_BGE  = 4'd4,
        OP_BLTU = 4'd5,
        OP_BGEU = 4'd6,
        OP_JAL  = 4'd7,
        OP_JALR = 4'd8
    } ex_op_e;

    localparam logic [4:0]  LINK_X1 = 5'd1;
    localparam logic [4:0]  LINK_X5 = 5'd5;
    localparam int unsigned KILL_W  = 4;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

    // Unused encodings 9-15 behave exactly like NONE.
    function automatic ex_op_e decode_op(input logic [3:0] raw);
        if (raw > 4'd8) begin
            return OP_NONE;
        end
        return ex_op_e'(raw);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. Pushing while full overwrites the oldest entry;
// popping while empty is ignored; push+pop together replaces the top in place.
module return_addr_stack #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_WIDTH-1:0]        wdata,
    output logic [ADDR_WIDTH-1:0]        top,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      top_idx;

    // ptr names the next free slot, so the top lives one below it.
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr   <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && pop) begin
            mem[top_idx] <= wdata;
        end else if (push) begin
            mem[ptr] <= wdata;
            ptr      <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: checks fetch's next-PC guess, drives the predictor
// feedback bus, maintains the return-address stack and squashes younger work on a miss.
module branch_resolve_unit
    import brp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned RAS_DEPTH   = 8,
    parameter int unsigned KILL_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_READY_DATA,
    input  logic                  EX_VALID,
    input  logic [ADDR_WIDTH-1:0] EX_PC,
    input  logic [3:0]            EX_OP,
    input  logic [31:0]           EX_RS1,
    input  logic [31:0]           EX_RS2,
    input  logic [31:0]           EX_IMM,
    input  logic [4:0]            EX_RD,
    input  logic [4:0]            EX_RS1_IDX,
    input  logic [ADDR_WIDTH-1:0] EX_PRD_ADDR,
    output logic                  BRANCH,
    output logic                  BRANCH_TAKEN,
    output logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
    output logic                  PREDICTED,
    output logic                  FLUSH,
    output logic                  RETURN,
    output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
    output logic [31:0]           BR_COUNT,
    output logic [31:0]           MISS_COUNT
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    ex_op_e                op;
    logic                  adv;
    logic                  live;
    logic                  is_ctl;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] pc_rel;
    logic [ADDR_WIDTH-1:0] jalr_tgt;
    logic [31:0]           jalr_sum;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  mispredict;
    logic                  push;
    logic                  pop;
    logic [KILL_W-1:0]     kill_cnt;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic [CNT_W-1:0]      ras_count;

    assign op  = decode_op(EX_OP);
    assign adv = CACHE_READY & CACHE_READY_DATA;

    // Reset is folded in so the outputs present their idle values while RST_N is low.
    assign live = RST_N & EX_VALID & (kill_cnt == '0);

    assign pc_rel   = EX_PC + ADDR_WIDTH'($signed(EX_IMM));
    assign jalr_sum = EX_RS1 + EX_IMM;
    assign jalr_tgt = ADDR_WIDTH'(jalr_sum) & ~ADDR_WIDTH'(1);
    assign seq_pc   = EX_PC + ADDR_WIDTH'(4);

    always_comb begin
        is_ctl = 1'b1;
        taken  = 1'b0;
        target = pc_rel;
        case (op)
            OP_BEQ:  taken = (EX_RS1 == EX_RS2);
            OP_BNE:  taken = (EX_RS1 != EX_RS2);
            OP_BLT:  taken = ($signed(EX_RS1) <  $signed(EX_RS2));
            OP_BGE:  taken = ($signed(EX_RS1) >= $signed(EX_RS2));
            OP_BLTU: taken = (EX_RS1 <  EX_RS2);
            OP_BGEU: taken = (EX_RS1 >= EX_RS2);
            OP_JAL:  taken = 1'b1;
            OP_JALR: begin
                taken  = 1'b1;
                target = jalr_tgt;
            end
            default: is_ctl = 1'b0;
        endcase
    end

    assign next_pc    = taken ? target : seq_pc;
    assign mispredict = live & (EX_PRD_ADDR != next_pc);

    assign BRANCH       = live & is_ctl;
    assign BRANCH_TAKEN = live & taken;
    assign BRANCH_ADDR  = RST_N ? target : '0;
    assign PREDICTED    = ~mispredict;
    assign FLUSH        = ~live;

    assign push = ((op == OP_JAL) || (op == OP_JALR)) && is_link(EX_RD);
    assign pop  = (op == OP_JALR) && is_link(EX_RS1_IDX)
                  && !(is_link(EX_RD) && (EX_RD == EX_RS1_IDX));

    assign RETURN      = live & pop;
    assign RETURN_ADDR = ras_top;

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (RAS_DEPTH)
    ) u_ras (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (live & adv & push),
        .pop   (live & adv & pop),
        .wdata (seq_pc),
        .top   (ras_top),
        .count (ras_count)
    );

    always_comb begin
        assert (ras_count <= CNT_W'(RAS_DEPTH));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            kill_cnt <= '0;
        end else if (adv && mispredict) begin
            kill_cnt <= KILL_W'(KILL_CYCLES);
        end else if (adv && (kill_cnt != '0)) begin
            kill_cnt <= kill_cnt - KILL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BR_COUNT   <= '0;
            MISS_COUNT <= '0;
        end else if (adv) begin
            BR_COUNT   <= BR_COUNT + {31'd0, BRANCH};
            MISS_COUNT <= MISS_COUNT + {31'd0, mispredict};
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// compared against a behavioural model (queue-based RAS, integer squash counter).
module tb_branch_resolve_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned KC    = 2;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          cr, crd, ex_valid;
    logic [31:0]   pc, rs1, rs2, imm, prd;
    logic [3:0]    ex_op;
    logic [4:0]    rd, rs1i;
    logic          BRANCH, BRANCH_TAKEN, PREDICTED, FLUSH, RETURN;
    logic [31:0]   BRANCH_ADDR, RETURN_ADDR, BR_COUNT, MISS_COUNT;

    always #5 CLK = ~CLK;

    branch_resolve_unit #(
        .ADDR_WIDTH  (AW),
        .RAS_DEPTH   (DEPTH),
        .KILL_CYCLES (KC)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .CACHE_READY      (cr),
        .CACHE_READY_DATA (crd),
        .EX_VALID         (ex_valid),
        .EX_PC            (pc),
        .EX_OP            (ex_op),
        .EX_RS1           (rs1),
        .EX_RS2           (rs2),
        .EX_IMM           (imm),
        .EX_RD            (rd),
        .EX_RS1_IDX       (rs1i),
        .EX_PRD_ADDR      (prd),
        .BRANCH           (BRANCH),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_ADDR      (BRANCH_ADDR),
        .PREDICTED        (PREDICTED),
        .FLUSH            (FLUSH),
        .RETURN           (RETURN),
        .RETURN_ADDR      (RETURN_ADDR),
        .BR_COUNT         (BR_COUNT),
        .MISS_COUNT       (MISS_COUNT)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    int          m_kill;
    logic [31:0] m_br, m_miss;
    logic [31:0] m_ras[$];

    logic        e_live, e_branch, e_taken, e_pred, e_ret, e_push, e_pop;
    logic [31:0] e_addr;

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    task automatic ref_resolve(input logic [3:0] o, input logic [31:0] p, a, b, i,
                               output bit tk, output bit ctl, output logic [31:0] tgt,
                               output logic [31:0] npc);
        int op;
        op  = (o > 4'd8) ? 0 : int'(o);
        tgt = (op == 8) ? ((a + i) & 32'hFFFF_FFFE) : (p + i);
        ctl = (op != 0);
        case (op)
            1: tk = (a == b);
            2: tk = (a != b);
            3: tk = ($signed(a) < $signed(b));
            4: tk = ($signed(a) >= $signed(b));
            5: tk = (a < b);
            6: tk = (a >= b);
            7, 8: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        npc = tk ? tgt : p + 32'd4;
    endtask

    task automatic model_eval();
        bit tk, ctl;
        logic [31:0] tgt, npc;
        ref_resolve(ex_op, pc, rs1, rs2, imm, tk, ctl, tgt, npc);
        e_live   = RST_N && ex_valid && (m_kill == 0);
        e_branch = e_live && ctl;
        e_taken  = e_live && tk;
        e_addr   = RST_N ? tgt : 32'd0;
        e_pred   = !e_live || (prd == npc);
        e_push   = (ex_op == 4'd7 || ex_op == 4'd8) && lnk(rd);
        e_pop    = (ex_op == 4'd8) && lnk(rs1i) && !(lnk(rd) && rd == rs1i);
        e_ret    = e_live && e_pop;
    endtask

    task automatic model_commit();
        bit adv;
        adv = cr && crd;
        if (!adv) return;
        if (!e_pred) m_kill = KC;
        else if (m_kill > 0) m_kill--;
        if (e_branch) m_br++;
        if (!e_pred) m_miss++;
        if (e_live) begin
            if (e_push && e_pop) begin
                if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = pc + 32'd4;
            end else if (e_push) begin
                if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                m_ras.push_back(pc + 32'd4);
            end else if (e_pop) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
            end
        end
    endtask

    task automatic model_reset();
        m_kill = 0;
        m_br   = '0;
        m_miss = '0;
        m_ras.delete();
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        check_eq({tag, ".branch"}, BRANCH, e_branch);
        check_eq({tag, ".taken"},  BRANCH_TAKEN, e_taken);
        check_eq({tag, ".addr"},   BRANCH_ADDR, e_addr);
        check_eq({tag, ".pred"},   PREDICTED, e_pred);
        check_eq({tag, ".flush"},  FLUSH, !e_live);
        check_eq({tag, ".ret"},    RETURN, e_ret);
        check_eq({tag, ".brcnt"},  BR_COUNT, m_br);
        check_eq({tag, ".miss"},   MISS_COUNT, m_miss);
        check_eq({tag, ".rascnt"}, dut.u_ras.count, m_ras.size());
        if (m_ras.size() > 0) check_eq({tag, ".rtop"}, RETURN_ADDR, m_ras[m_ras.size() - 1]);
    endtask

    // One cycle: compare on the falling edge, advance the model, cross the rising edge.
    task automatic step(input string tag);
        @(negedge CLK);
        check_outputs(tag);
        model_commit();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic [3:0] o, input logic [31:0] p, a, b, i,
                          input logic [4:0] d, s, input logic [31:0] pr);
        ex_op = o; pc = p; rs1 = a; rs2 = b; imm = i; rd = d; rs1i = s; prd = pr;
        ex_valid = 1'b1;
    endtask

    task automatic set_nop(input logic [31:0] p);
        set_ex(4'd0, p, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, p + 32'd4);
    endtask

    initial begin
        bit tk, ctl;
        logic [31:0] tgt, npc;

        RST_N = 1'b0; cr = 1'b1; crd = 1'b1;
        set_nop(32'h0);
        ex_valid = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset");
        check_eq("reset.rtop", RETURN_ADDR, 32'd0);
        check_eq("reset.flush_c", FLUSH, 1'b1);
        RST_N = 1'b1;

        // 1: correctly predicted taken BEQ
        set_ex(4'd1, 32'h100, 32'd5, 32'd5, 32'h40, 5'd0, 5'd0, 32'h140);
        #1;
        check_eq("t1.branch", BRANCH, 1'b1);
        check_eq("t1.taken", BRANCH_TAKEN, 1'b1);
        check_eq("t1.addr", BRANCH_ADDR, 32'h140);
        check_eq("t1.pred", PREDICTED, 1'b1);
        check_eq("t1.flush", FLUSH, 1'b0);
        step("t1");

        // 2: mispredicted BNE, two squash cycles
        set_ex(4'd2, 32'h200, 32'd7, 32'd7, 32'h80, 5'd0, 5'd0, 32'h280);
        #1;
        check_eq("t2.pred", PREDICTED, 1'b0);
        check_eq("t2.taken", BRANCH_TAKEN, 1'b0);
        step("t2");
        for (int i = 0; i < 2; i++) begin
            set_nop(32'h204 + 32'(i * 4));
            #1;
            check_eq("t2.kill", FLUSH, 1'b1);
            step("t2k");
        end
        set_nop(32'h20c);
        #1;
        check_eq("t2.free", FLUSH, 1'b0);
        check_eq("t2.miss", MISS_COUNT, 32'd1);
        step("t2f");

        // 3: squash holds while caches stall
        set_ex(4'd2, 32'h200, 32'd7, 32'd7, 32'h80, 5'd0, 5'd0, 32'h280);
        step("t3");
        set_nop(32'h204);
        cr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t3.stall", FLUSH, 1'b1);
            step("t3s");
        end
        cr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq("t3.kill", FLUSH, 1'b1);
            step("t3k");
        end
        #1;
        check_eq("t3.free", FLUSH, 1'b0);
        step("t3f");

        // 4: call then return
        set_ex(4'd7, 32'h300, 32'd0, 32'd0, 32'h100, 5'd1, 5'd0, 32'h400);
        step("t4c");
        set_ex(4'd8, 32'h400, 32'h304, 32'd0, 32'd0, 5'd0, 5'd1, 32'h304);
        #1;
        check_eq("t4.rtop", RETURN_ADDR, 32'h304);
        check_eq("t4.ret", RETURN, 1'b1);
        step("t4r");
        #1;
        check_eq("t4.cnt", dut.u_ras.count, 32'd0);

        // 5: overflow wrap then underflow
        for (int i = 0; i < 9; i++) begin
            set_ex(4'd7, 32'(i * 4), 32'd0, 32'd0, 32'd0, 5'd1, 5'd0, 32'(i * 4));
            step("t5p");
        end
        #1;
        check_eq("t5.top", RETURN_ADDR, 32'h24);
        check_eq("t5.cnt", dut.u_ras.count, 32'd8);
        for (int i = 0; i < 9; i++) begin
            set_ex(4'd8, 32'h800, 32'h900, 32'd0, 32'd0, 5'd0, 5'd5, 32'h900);
            #1;
            if (i < 8) check_eq("t5.pop", RETURN_ADDR, 32'h24 - 32'(i * 4));
            step("t5o");
        end
        #1;
        check_eq("t5.empty", dut.u_ras.count, 32'd0);

        // 6: async reset during squash
        set_ex(4'd2, 32'h200, 32'd7, 32'd7, 32'h80, 5'd0, 5'd0, 32'h280);
        step("t6");
        set_nop(32'h204);
        RST_N = 1'b0;
        #1;
        check_eq("t6.flush", FLUSH, 1'b1);
        check_eq("t6.br", BR_COUNT, 32'd0);
        check_eq("t6.miss", MISS_COUNT, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
        check_eq("t6.free", FLUSH, 1'b0);
        step("t6f");

        // 7: signed/unsigned compares and JALR alignment
        set_ex(4'd3, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0, 5'd0, 32'h520);
        #1;
        check_eq("t7.blt", BRANCH_TAKEN, 1'b1);
        step("t7a");
        set_ex(4'd5, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd0, 5'd0, 32'h604);
        #1;
        check_eq("t7.bltu", BRANCH_TAKEN, 1'b0);
        step("t7b");
        set_ex(4'd8, 32'h700, 32'h1001, 32'd0, 32'd0, 5'd0, 5'd0, 32'h1000);
        #1;
        check_eq("t7.jalr", BRANCH_ADDR, 32'h1000);
        step("t7c");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            ex_op    = 4'($urandom_range(0, 15));
            pc       = {$urandom_range(0, 32'hFFFF), 2'b00};
            rs1      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 6)) - 3);
            rs2      = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 6)) - 3);
            imm      = 32'($signed($urandom_range(0, 512)) - 256);
            rd       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : (($urandom_range(0, 1) == 1) ? 5'd1 : 5'd5);
            rs1i     = ($urandom_range(0, 2) == 0) ? 5'($urandom) : (($urandom_range(0, 1) == 1) ? 5'd1 : 5'd5);
            ex_valid = ($urandom_range(0, 7) != 0);
            cr       = ($urandom_range(0, 5) != 0);
            crd      = ($urandom_range(0, 5) != 0);
            ref_resolve(ex_op, pc, rs1, rs2, imm, tk, ctl, tgt, npc);
            prd      = ($urandom_range(0, 4) != 0) ? npc : npc + 32'd4;
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
